// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus adapter: FSM states, lane geometry
// and the READ_WRITE / WORD_BYTE request encodings.
package mem_bus_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic WB_WORD  = 1'b1;
  localparam logic WB_BYTE  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/read_lane_assembler.sv
// Collects byte lanes returned by the RAM and publishes the whole load value
// to RDATA in one step, so RDATA never exposes a partially assembled word.
module read_lane_assembler
  import mem_bus_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cap_en,
  input  logic [LANE_W-1:0] cap_idx,
  input  logic [BYTE_W-1:0] mem_rdata,
  input  logic              commit,
  input  logic              word,
  output logic [WORD_W-1:0] rdata
);

  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] acc_q;
  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] merged;

  // The final lane is merged combinationally so commit needs no extra cycle.
  always_comb begin
    merged          = acc_q;
    merged[cap_idx] = mem_rdata;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      acc_q <= '0;
      rdata <= '0;
    end else begin
      if (cap_en) acc_q <= merged;
      if (commit) rdata <= word ? merged : WORD_W'(mem_rdata);
    end
  end

endmodule

// File: rtl/memory_bus_adapter.sv
// Four-phase MFA/MFC adapter from a 32-bit CPU memory port to a byte-wide RAM.
// Optional misaligned-word fault reporting: define MEM_ADAPTER_MISALIGN_FAULT_EN.
module memory_bus_adapter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MFA,
  input  logic              READ_WRITE,
  input  logic              WORD_BYTE,
  input  logic [31:0]       ADDR,
  input  logic [31:0]       WDATA,
  output logic [31:0]       RDATA,
  output logic              MFC,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata
`ifdef MEM_ADAPTER_MISALIGN_FAULT_EN
  ,
  output logic              FAULT
`endif
);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   cnt_q;
  logic                rw_q, wb_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                load;
  logic                last_beat;
  logic                misalign;
  logic                cap_en;
  logic [LANE_W-1:0]   cap_idx;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^ADDR[31:ADDR_W];

`ifdef MEM_ADAPTER_MISALIGN_FAULT_EN
  logic fault_q;
  assign misalign = (WORD_BYTE == WB_WORD) && (ADDR[1:0] != 2'b00);
  assign FAULT    = fault_q;
`else
  assign misalign = 1'b0;
`endif

  assign last_beat = (wb_q == WB_WORD) ? (cnt_q == LANE_W'(BYTES_PER_WORD - 1))
                                       : (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (MFA && !MFC) begin
          load    = 1'b1;
          state_d = misalign ? DONE : BEAT;
        end
      end
      BEAT:    if (last_beat) state_d = (rw_q == RW_READ) ? DRAIN : DONE;
      DRAIN:   state_d = DONE;
      DONE:    if (!MFA) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= RW_WRITE;
      wb_q    <= WB_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        rw_q    <= READ_WRITE;
        wb_q    <= WORD_BYTE;
        addr_q  <= (WORD_BYTE == WB_WORD) ? {ADDR[ADDR_W-1:2], 2'b00} : ADDR[ADDR_W-1:0];
        wdata_q <= WDATA;
        cnt_q   <= '0;
      end else if (state_q == BEAT) begin
        cnt_q <= cnt_q + LANE_W'(1);
      end
    end
  end

`ifdef MEM_ADAPTER_MISALIGN_FAULT_EN
  // Fault flag lives exactly as long as the DONE state it was raised into.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) fault_q <= 1'b0;
    else        fault_q <= (state_d == DONE) && (fault_q || (load && misalign));
  end
`endif

  assign MFC       = (state_q == DONE);
  assign mem_en    = (state_q == BEAT);
  assign mem_we    = mem_en && (rw_q == RW_WRITE);
  assign mem_addr  = mem_en ? addr_q + ADDR_W'(cnt_q) : '0;
  assign mem_wdata = mem_we ? wdata_q[cnt_q*BYTE_W +: BYTE_W] : '0;

  // RAM data lags its beat by one cycle: capture lane k while issuing beat k+1,
  // and the last lane during DRAIN.
  assign cap_en  = (rw_q == RW_READ) && (((state_q == BEAT) && (cnt_q != '0)) || (state_q == DRAIN));
  assign cap_idx = (state_q == DRAIN) ? ((wb_q == WB_WORD) ? LANE_W'(BYTES_PER_WORD - 1) : '0)
                                      : cnt_q - LANE_W'(1);

  read_lane_assembler u_read_lane_assembler (
    .Clk       (Clk),
    .Reset     (Reset),
    .cap_en    (cap_en),
    .cap_idx   (cap_idx),
    .mem_rdata (mem_rdata),
    .commit    (state_q == DRAIN),
    .word      (wb_q == WB_WORD),
    .rdata     (RDATA)
  );

endmodule

// File: tb/tb_memory_bus_adapter.sv
// Scoreboard bench for memory_bus_adapter: driver queues expected RAM beats and
// MFC responses from a byte-array model; a negedge monitor pops and compares.
module tb_memory_bus_adapter;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned RAM_SIZE = 1 << ADDR_W;

  typedef struct {
    bit          is_read;
    bit          fault;
    logic [31:0] rdata;
    int unsigned lat;
    int unsigned dur;
    int unsigned issue_edge;
  } resp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    bit                we;
    logic [7:0]        wdata;
  } beat_t;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              MFA = 1'b0;
  logic              READ_WRITE = 1'b0;
  logic              WORD_BYTE = 1'b0;
  logic [31:0]       ADDR = '0;
  logic [31:0]       WDATA = '0;
  logic [31:0]       RDATA;
  logic              MFC;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = '0;
`ifdef MEM_ADAPTER_MISALIGN_FAULT_EN
  logic              FAULT;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  logic [7:0] ref_mem [RAM_SIZE];
  logic [7:0] ram [RAM_SIZE];
  bit         ram_loaded = 1'b0;

  resp_t resp_q[$];
  beat_t beat_q[$];

  logic [31:0] rd_shown = '0;
  bit          mfc_prev = 1'b0;
  int unsigned rise_cyc = 0;
  int unsigned dur_exp = 0;

  always #5 Clk = ~Clk;

  memory_bus_adapter #(.ADDR_W(ADDR_W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .MFA        (MFA),
    .READ_WRITE (READ_WRITE),
    .WORD_BYTE  (WORD_BYTE),
    .ADDR       (ADDR),
    .WDATA      (WDATA),
    .RDATA      (RDATA),
    .MFC        (MFC),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef MEM_ADAPTER_MISALIGN_FAULT_EN
    ,
    .FAULT      (FAULT)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Byte-wide RAM with one-cycle read latency; preloaded from the model image.
  always @(posedge Clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < RAM_SIZE; i++) ram[i] <= ref_mem[i];
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  always @(negedge Clk) begin
    if (Reset) begin
      if (mem_en) begin
        if (beat_q.size() == 0) chk("unexpected_beat", 32'(beat_q.size()), 32'd1);
        else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_addr", 32'(mem_addr), 32'(b.addr));
          chk("beat_we", 32'(mem_we), 32'(b.we));
          if (b.we) chk("beat_wdata", 32'(mem_wdata), 32'(b.wdata));
        end
      end else begin
        chk("idle_we", 32'(mem_we), 32'd0);
      end
      if (MFC && !mfc_prev) begin
        if (resp_q.size() == 0) chk("unexpected_mfc", 32'(resp_q.size()), 32'd1);
        else begin
          resp_t r;
          r = resp_q.pop_front();
          chk("mfc_latency", 32'(cyc - r.issue_edge), 32'(r.lat));
          if (r.is_read && !r.fault) rd_shown = r.rdata;
          rise_cyc = cyc;
          dur_exp  = r.dur;
`ifdef MEM_ADAPTER_MISALIGN_FAULT_EN
          chk("fault_flag", 32'(FAULT), 32'(r.fault));
`endif
        end
      end
`ifdef MEM_ADAPTER_MISALIGN_FAULT_EN
      if (!MFC) chk("fault_idle", 32'(FAULT), 32'd0);
`endif
      if (!MFC && mfc_prev) chk("mfc_width", 32'(cyc - rise_cyc), 32'(dur_exp));
      chk("rdata_hold", RDATA, rd_shown);
      mfc_prev = MFC;
    end
  end

  task automatic do_txn(input bit rd, input bit wb, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit pulse, input int unsigned hold);
    resp_t             r;
    bit                fault;
    logic [ADDR_W-1:0] base;
    int unsigned       n;
    bit                seen;
    fault = 1'b0;
`ifdef MEM_ADAPTER_MISALIGN_FAULT_EN
    fault = wb && (addr[1:0] != 2'b00);
`endif
    base = wb ? {addr[ADDR_W-1:2], 2'b00} : addr[ADDR_W-1:0];
    n    = fault ? 0 : (wb ? 4 : 1);
    for (int unsigned k = 0; k < n; k++) begin
      beat_t b;
      b.addr  = base + ADDR_W'(k);
      b.we    = !rd;
      b.wdata = wdata[8*k +: 8];
      beat_q.push_back(b);
      if (!rd) ref_mem[b.addr] = b.wdata;
    end
    r.is_read = rd;
    r.fault   = fault;
    r.rdata   = wb ? {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]}
                   : {24'h0, ref_mem[base]};
    r.lat     = fault ? 1 : (rd ? (wb ? 5 : 2) : (wb ? 4 : 1));
    r.dur     = pulse ? 1 : hold + 1;
    @(posedge Clk); #1;
    MFA = 1'b1; READ_WRITE = rd; WORD_BYTE = wb; ADDR = addr; WDATA = wdata;
    r.issue_edge = cyc + 1;
    resp_q.push_back(r);
    if (pulse) begin
      @(posedge Clk); #1;
      MFA = 1'b0; READ_WRITE = 1'($urandom); WORD_BYTE = 1'($urandom);
      ADDR = $urandom; WDATA = $urandom;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge Clk); #1;
      if (MFC) seen = 1'b1;
    end
    if (!seen) begin
      chk("mfc_timeout", 32'(seen), 32'd1);
      MFA = 1'b0;
      return;
    end
    if (!pulse) begin
      repeat (hold) @(posedge Clk);
      #1 MFA = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge Clk); #1;
      if (!MFC) seen = 1'b1;
    end
    if (!seen) chk("mfc_release_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    bit          seen;
    int unsigned errs;
    for (int i = 0; i < RAM_SIZE; i++) ref_mem[i] = 8'($urandom);
    ref_mem[12'h10] = 8'h11; ref_mem[12'h11] = 8'h22;
    ref_mem[12'h12] = 8'h33; ref_mem[12'h13] = 8'h44;
    for (int i = 12'h30; i < 12'h34; i++) ref_mem[i] = 8'hFF;
    ref_mem[12'h07] = 8'h9C;

    #1;
    chk("reset_mfc", 32'(MFC), 32'd0);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("reset_rdata", RDATA, 32'd0);
    #11 Reset = 1'b1;

    do_txn(1'b1, 1'b1, 32'h0000_0010, 32'h0, 1'b0, 1);
    chk("word_read_0x10", RDATA, 32'h4433_2211);
    do_txn(1'b0, 1'b0, 32'h0000_0021, 32'hDEAD_BEA5, 1'b0, 0);
    chk("byte_write_0x21", 32'(ram[12'h21]), 32'h0000_00A5);
    do_txn(1'b1, 1'b1, 32'h0000_0030, 32'h0, 1'b0, 0);
    chk("word_read_ones", RDATA, 32'hFFFF_FFFF);
    do_txn(1'b1, 1'b0, 32'h0000_0007, 32'h0, 1'b0, 2);
    chk("byte_read_zext", RDATA, 32'h0000_009C);
    do_txn(1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1'b1, 0);
    chk("pulsed_word_write", {ram[12'h43], ram[12'h42], ram[12'h41], ram[12'h40]}, 32'hCAFE_F00D);
`ifdef MEM_ADAPTER_MISALIGN_FAULT_EN
    do_txn(1'b1, 1'b1, 32'h0000_0013, 32'h0, 1'b0, 0);
    chk("misaligned_rdata_kept", RDATA, 32'h0000_009C);
`endif

    // Reset in the middle of a word write: only beats 0 and 1 reach the RAM.
    w = $urandom;
    for (int unsigned k = 0; k < 4; k++) begin
      beat_t b;
      b.addr = ADDR_W'(12'h80 + k); b.we = 1'b1; b.wdata = w[8*k +: 8];
      beat_q.push_back(b);
    end
    @(posedge Clk); #1;
    MFA = 1'b1; READ_WRITE = 1'b0; WORD_BYTE = 1'b1; ADDR = 32'h80; WDATA = w;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clk);
      if (mem_en && mem_addr == 12'h82) seen = 1'b1;
    end
    chk("rst_beat2_seen", 32'(seen), 32'd1);
    #2 Reset = 1'b0; MFA = 1'b0; rd_shown = '0;
    #1;
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_mfc", 32'(MFC), 32'd0);
    chk("midrst_rdata", RDATA, 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    beat_q.delete();
    ref_mem[12'h80] = w[7:0];
    ref_mem[12'h81] = w[15:8];
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b1;
    do_txn(1'b1, 1'b1, 32'h0000_0080, 32'h0, 1'b0, 0);
    chk("read_after_reset", RDATA, {ref_mem[12'h83], ref_mem[12'h82], w[15:8], w[7:0]});

    for (int i = 0; i < 150; i++) begin
      do_txn(1'($urandom), 1'($urandom), $urandom, $urandom,
             ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(posedge Clk);
    end

    repeat (4) @(posedge Clk);
    chk("beats_drained", 32'(beat_q.size()), 32'd0);
    chk("responses_drained", 32'(resp_q.size()), 32'd0);
    errs = 0;
    for (int i = 0; i < RAM_SIZE; i++) if (ram[i] !== ref_mem[i]) errs++;
    chk("ram_image", 32'(errs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_bus_adapter.md
MEMORY_BUS_ADAPTER -- requirements
Module: memory_bus_adapter

Interface
REQ-001 Parameter ADDR_W, default 12: byte-address width of the external byte-wide RAM.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset, asynchronous, active-low.
REQ-004 MFA  input  1  memory function active; request from control unit, held until MFC seen.
REQ-005 READ_WRITE  input  1  1 = read, 0 = write; sampled with MFA.
REQ-006 WORD_BYTE  input  1  1 = 32-bit word, 0 = byte; sampled with MFA.
REQ-007 ADDR  input  32  byte address from MAR.
REQ-008 WDATA  input  32  store data from MBR.
REQ-009 RDATA  output  32  load data to MBR; holds until next read completes.
REQ-010 MFC  output  1  memory function complete.
REQ-011 mem_en / mem_we  output  1 each  RAM enable and write strobe.
REQ-012 mem_addr  output  ADDR_W  RAM byte address.
REQ-013 mem_wdata / mem_rdata  output / input  8 each  RAM data; read data valid the cycle after the mem_en read cycle.

Function
REQ-014 FSM states: IDLE, BEAT, DRAIN, DONE.
REQ-015 IDLE: on MFA=1 and MFC=0, register READ_WRITE, WORD_BYTE, ADDR[ADDR_W-1:0], WDATA; clear beat counter; go to BEAT.
REQ-016 Word access forces address bits [1:0] to 0; beats k=0..3 address base+k; byte access issues one beat at ADDR.
REQ-017 BEAT: one beat per cycle, mem_en=1, mem_we=~READ_WRITE, mem_wdata = WDATA[8k+7:8k]; after last beat: reads go to DRAIN, writes go to DONE.
REQ-018 Read lanes little-endian: byte k lands in RDATA[8k+7:8k]; byte read zero-extends into RDATA[7:0].
REQ-019 DRAIN: capture final mem_rdata, commit the full RDATA atomically, go to DONE; RDATA never shows partial words.
REQ-020 Latency, counted in edges after the edge that samples MFA: MFC=1 after 5 (word read), 2 (byte read), 4 (word write), 1 (byte write).
REQ-021 DONE: MFC=1 while MFA=1 (four-phase); on MFA=0 sampled, MFC=0 next edge and return to IDLE.
REQ-022 MFA dropping during BEAT/DRAIN does not abort; transfer completes, MFC high exactly one cycle, then IDLE.
REQ-023 No new request accepted while MFC=1; MFA high continuously after DONE is not a new request.
REQ-024 mem_en=0 and mem_we=0 in IDLE and DONE.

Reset
REQ-025 Reset low: immediately MFC=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, RDATA=0, state IDLE, counter 0.
REQ-026 Reset mid-transfer: abandon transfer with no further RAM writes; first request is accepted on the first rising edge after release with MFA=1.

Configuration
REQ-027 Macro MEM_ADAPTER_MISALIGN_FAULT_EN defined: add output FAULT (1 bit, reset 0); word access with ADDR[1:0]!=0 skips BEAT, issues no RAM cycle, goes to DONE with FAULT=1 alongside MFC and RDATA unchanged; FAULT clears with MFC.
REQ-028 Macro undefined: no FAULT port; ADDR[1:0] silently ignored for word accesses per REQ-016.

Structure
REQ-029 Shared package mem_bus_pkg holds the state enum, BYTES_PER_WORD=4, BYTE_W=8 and the READ/WRITE and WORD/BYTE encodings.
REQ-030 One sub-module, read_lane_assembler: takes beat index and mem_rdata, accumulates lanes, commits to RDATA on commit strobe.

Verification
REQ-031 Word read, RAM[0x10..0x13]=11,22,33,44, ADDR=0x10, MFA held -> mem_addr 0x10..0x13 consecutive, MFC at edge 5, RDATA=0x44332211.
REQ-032 Byte write, ADDR=0x21, WDATA=0xDEADBEA5 -> single beat, mem_we=1, mem_addr=0x21, mem_wdata=0xA5, MFC at edge 1; RAM[0x21]=0xA5 only.
REQ-033 Byte read of RAM[0x07]=0x9C with prior RDATA=0xFFFFFFFF -> RDATA=0x0000009C.
REQ-034 MFA pulsed one cycle for word write 0xCAFEF00D @0x40 -> four beats, RAM holds 0D,F0,FE,CA; MFC high one cycle only.
REQ-035 Reset low during beat 2 of word write -> mem_we=0 at once, no further writes, MFC=0; next read after release returns correct data.
REQ-036 With MEM_ADAPTER_MISALIGN_FAULT_EN, word read ADDR=0x13 -> no mem_en, FAULT=1 with MFC, RDATA unchanged.
